// File: rtl/g729_dsp_pkg.sv
// Shared G.729 fixed-point helpers and the Inv_sqrt table (basic-op semantics).
package g729_dsp_pkg;

  localparam int unsigned INV_SQRT_TAB_LEN = 49;
  localparam logic [31:0] INV_SQRT_SPECIAL = 32'h3FFF_FFFF;
  localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;

  typedef logic [5:0] tab_addr_t;

  localparam logic [15:0] TABSQR [INV_SQRT_TAB_LEN] = '{
    16'd32767, 16'd31790, 16'd30894, 16'd30070, 16'd29309, 16'd28602, 16'd27945,
    16'd27330, 16'd26755, 16'd26214, 16'd25705, 16'd25225, 16'd24770, 16'd24339,
    16'd23930, 16'd23541, 16'd23170, 16'd22817, 16'd22479, 16'd22155, 16'd21845,
    16'd21548, 16'd21263, 16'd20988, 16'd20724, 16'd20470, 16'd20225, 16'd19988,
    16'd19760, 16'd19539, 16'd19326, 16'd19119, 16'd18919, 16'd18725, 16'd18536,
    16'd18354, 16'd18176, 16'd18004, 16'd17837, 16'd17674, 16'd17515, 16'd17361,
    16'd17211, 16'd17064, 16'd16921, 16'd16782, 16'd16646, 16'd16514, 16'd16384
  };

  // Leading-sign count: shifts needed to bring the first non-sign bit to bit 30.
  function automatic logic [4:0] norm_l(input logic [31:0] x);
    logic found;
    norm_l = 5'd0;
    found  = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (!found && (x[i] != x[31])) begin
        norm_l = 5'(30 - i);
        found  = 1'b1;
      end
    end
  endfunction

  function automatic logic signed [15:0] sub_16(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [16:0] d;
    d = 17'(a) - 17'(b);
    if (d[16] != d[15]) return d[16] ? 16'sh8000 : 16'sh7FFF;
    return d[15:0];
  endfunction

  function automatic logic signed [31:0] l_mult(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    if (p == 32'sh4000_0000) return MAX_32;
    return p <<< 1;
  endfunction

  function automatic logic signed [31:0] l_sub(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [32:0] d;
    d = 33'(a) - 33'(b);
    if (d[32] != d[31]) return d[32] ? MIN_32 : MAX_32;
    return d[31:0];
  endfunction

  function automatic logic signed [31:0] l_msu(input logic signed [31:0] acc,
                                               input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return l_sub(acc, l_mult(a, b));
  endfunction

  function automatic logic signed [31:0] l_shr(input logic signed [31:0] x,
                                               input logic [4:0] n);
    return x >>> n;
  endfunction

endpackage

// File: rtl/inv_sqrt_rom.sv
// 49x16 Inv_sqrt table with two registered read ports; holds its outputs while en_i is low.
module inv_sqrt_rom
  import g729_dsp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  tab_addr_t   addr_a_i,
  input  tab_addr_t   addr_b_i,
  output logic [15:0] data_a_o,
  output logic [15:0] data_b_o
);

  logic [15:0] data_a_q, data_a_d;
  logic [15:0] data_b_q, data_b_d;

  function automatic logic [15:0] rd(input tab_addr_t addr);
    rd = 16'd0;
    if (32'(addr) < INV_SQRT_TAB_LEN) rd = TABSQR[addr];
  endfunction

  always_comb begin
    data_a_d = rd(addr_a_i);
    data_b_d = rd(addr_b_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_a_q <= 16'd0;
      data_b_q <= 16'd0;
    end else if (en_i) begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;

endmodule

// File: rtl/inv_sqrt_pipe_n.sv
// Pipelined bit-exact G.729 Inv_sqrt with valid/ready and a request tag.
// Optional non-positive input counter built only when INV_SQRT_STATS_EN is defined.
module inv_sqrt_pipe_n
  import g729_dsp_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [15:0]      nonpos_cnt
);

  logic adv_c;

  logic             s1_v_q, s1_spec_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [21:0]      s1_xh_q, s1_xh_d;
  logic [4:0]       s1_exp_q, s1_exp_d, s1_e_d;
  logic             s1_spec_d;

  logic             s2_v_q, s2_spec_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [4:0]       s2_exp_q, s2_exp_d;
  logic [14:0]      s2_a_q, s2_a_d;
  logic [20:0]      s2_xs_c;
  tab_addr_t        s2_idx_d, s2_idx1_d;
  logic [15:0]      rom_a, rom_b;

  logic               s3_v_q, s3_spec_q;
  logic [TAG_W-1:0]   s3_tag_q;
  logic [4:0]         s3_exp_q;
  logic signed [31:0] s3_y_q, s3_y_d;
  logic signed [15:0] s3_tmp_c;
  logic [31:0]        s4_res_c;

  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  // Normalise; only x[31:10] is ever needed downstream.
  always_comb begin
    s1_spec_d = in_data[31] || (in_data == 32'd0);
    s1_e_d    = norm_l(in_data);
    s1_xh_d   = 22'((in_data << s1_e_d) >> 10);
    s1_exp_d  = 5'd30 - s1_e_d;
    if (s1_spec_d) begin
      s1_xh_d  = 22'h10_0000;
      s1_exp_d = 5'd0;
    end
  end

  // Even exponent halves x; xs holds x[30:10] after that adjustment.
  always_comb begin
    s2_xs_c   = s1_exp_q[0] ? s1_xh_q[20:0] : s1_xh_q[21:1];
    s2_exp_d  = (s1_exp_q >> 1) + 5'd1;
    s2_idx_d  = s2_xs_c[20:15] - 6'd16;
    s2_idx1_d = s2_idx_d + 6'd1;
    s2_a_d    = s2_xs_c[14:0];
  end

  inv_sqrt_rom u_rom (
    .clk      (clk),
    .reset    (reset),
    .en_i     (adv_c),
    .addr_a_i (s2_idx_d),
    .addr_b_i (s2_idx1_d),
    .data_a_o (rom_a),
    .data_b_o (rom_b)
  );

  always_comb begin
    s3_tmp_c = sub_16($signed(rom_a), $signed(rom_b));
    s3_y_d   = l_msu($signed({rom_a, 16'h0000}), s3_tmp_c, $signed({1'b0, s2_a_q}));
  end

  assign s4_res_c = s3_spec_q ? INV_SQRT_SPECIAL : l_shr(s3_y_q, s3_exp_q);

  // Stages 1..3 shift together on adv; bubbles are kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_tag_q  <= '0;
      s1_xh_q   <= 22'd0;
      s1_exp_q  <= 5'd0;
      s2_v_q    <= 1'b0;
      s2_spec_q <= 1'b0;
      s2_tag_q  <= '0;
      s2_exp_q  <= 5'd0;
      s2_a_q    <= 15'd0;
      s3_v_q    <= 1'b0;
      s3_spec_q <= 1'b0;
      s3_tag_q  <= '0;
      s3_exp_q  <= 5'd0;
      s3_y_q    <= 32'sd0;
    end else if (adv_c) begin
      s1_v_q    <= in_valid;
      s1_spec_q <= s1_spec_d;
      s1_tag_q  <= in_tag;
      s1_xh_q   <= s1_xh_d;
      s1_exp_q  <= s1_exp_d;
      s2_v_q    <= s1_v_q;
      s2_spec_q <= s1_spec_q;
      s2_tag_q  <= s1_tag_q;
      s2_exp_q  <= s2_exp_d;
      s2_a_q    <= s2_a_d;
      s3_v_q    <= s2_v_q;
      s3_spec_q <= s2_spec_q;
      s3_tag_q  <= s2_tag_q;
      s3_exp_q  <= s2_exp_q;
      s3_y_q    <= s3_y_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             s4_v_q;
      logic [31:0]      s4_data_q;
      logic [TAG_W-1:0] s4_tag_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s4_v_q    <= 1'b0;
          s4_data_q <= 32'd0;
          s4_tag_q  <= '0;
        end else if (adv_c) begin
          s4_v_q    <= s3_v_q;
          s4_data_q <= s4_res_c;
          s4_tag_q  <= s3_tag_q;
        end
      end

      assign out_valid = s4_v_q;
      assign out_data  = s4_data_q;
      assign out_tag   = s4_tag_q;
      assign busy      = s1_v_q || s2_v_q || s3_v_q || s4_v_q;
    end else begin : g_out_comb
      assign out_valid = s3_v_q;
      assign out_data  = s4_res_c;
      assign out_tag   = s3_tag_q;
      assign busy      = s1_v_q || s2_v_q || s3_v_q;
    end
  endgenerate

`ifdef INV_SQRT_STATS_EN
  logic [15:0] nonpos_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nonpos_cnt_q <= 16'd0;
    end else if (in_valid && adv_c && s1_spec_d && (nonpos_cnt_q != 16'hFFFF)) begin
      nonpos_cnt_q <= nonpos_cnt_q + 16'd1;
    end
  end

  assign nonpos_cnt = nonpos_cnt_q;
`else
  assign nonpos_cnt = 16'd0;
`endif

endmodule

// File: doc/inv_sqrt_pipe_n.md
Name: inv_sqrt_pipe_n

Overview:
- Fully pipelined, bit-exact G.729 Inv_sqrt: out = 1/sqrt(L_x), computed by normalisation, a 49-entry table lookup and linear interpolation.
- Accepts one request per cycle under valid/ready flow control. A tag rides with each request so several LPC/gain consumers can share one unit.
- Replaces the start/done FSM version, which took one operand at a time and read the table from constant memory. The table here is an internal ROM.

Parameters:
- TAG_W, 4: width of the request tag carried alongside the data; allowed range 1..16.
- OUT_REG, 1: 1 = registered output stage, latency 4; 0 = stage 4 is combinational off stage 3, latency 3.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_data  in  32  L_x, signed Q31 word
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  32  L_y result
- out_tag  out  TAG_W  tag of that result
- busy  out  1  at least one stage holds a valid entry
- nonpos_cnt  out  16  count of non-positive inputs (see Optional Feature)

Behaviour:
- Reset (async): all stage valid bits 0; out_valid=0, out_data=0, out_tag=0, busy=0, nonpos_cnt=0. in_ready=1 once reset deasserts. Reset mid-flight discards every in-flight entry.
- Advance: adv = !out_valid | out_ready. When adv=1 all stages shift by one; otherwise all stages hold. Bubbles are not squeezed out.
- in_ready = adv. A transfer occurs when in_valid & in_ready. Data and tag must be held stable while in_valid=1 and in_ready=0.
- Order: strictly in order. Latency is 4 cycles (OUT_REG=1) or 3 cycles (OUT_REG=0) from accept to out_valid, with no stalls. Throughput is 1 result per cycle.
- S1 (normalise):
  - If L_x <= 0, set flag special.
  - Otherwise: e = norm_l(L_x) via combinational leading-sign count; x = L_x << e; exp = 30 - e.
- S2 (index and table):
  - If exp is even, x = x >> 1.
  - exp = (exp >> 1) + 1.
  - i = ((x >> 9) >> 16) - 16, giving range 0..47.
  - a = (x >> 10) & 0x7FFF.
  - Read tab[i] and tab[i+1] from a dual-read registered ROM.
  - Table contents: 32767,31790,30894,30070,29309,28602,27945,27330,26755,26214,25705,25225,24770,24339,23930,23541,23170,22817,22479,22155,21845,21548,21263,20988,20724,20470,20225,19988,19760,19539,19326,19119,18919,18725,18536,18354,18176,18004,17837,17674,17515,17361,17211,17064,16921,16782,16646,16514,16384.
- S3 (interpolate):
  - tmp = tab[i] - tab[i+1].
  - y = (tab[i] << 16) - 2*tmp*a, with 32-bit saturation identical to L_msu.
- S4 (scale): y = y >>> exp, arithmetic shift. If special, the result is 0x3FFFFFFF instead.
- Stall boundary: a stalled out_data/out_tag pair stays stable until accepted. An accept and a new input in the same cycle are legal.
- busy = OR of all stage valid bits.

Optional Feature:
- Macro INV_SQRT_STATS_EN.
- Defined: nonpos_cnt increments on each accepted request with in_data <= 0. It saturates at 0xFFFF and clears only on reset.
- Undefined: no counter logic is built and nonpos_cnt is tied to 0.

Decomposition:
- Shared package g729_dsp_pkg holds:
  - INV_SQRT_TAB_LEN=49
  - INV_SQRT_SPECIAL=32'h3FFFFFFF
  - the tabsqr constant array
  - MAX_32 and MIN_32
- One sub-module, inv_sqrt_rom: a 49x16 registered ROM with two read ports, addresses i and i+1.
- norm, msu and shift logic stay inline, written as functions from the package.

Test Plan:
- in=0x40000000, out_ready=1 -> out_data=0x00007FFF exactly 4 cycles after accept; tag echoed.
- in=0x7FFFFFFF -> 0x00005A82. in=0x00000001 -> 0x3FFF8000. in=0x00000002 -> 0x2D410000.
- in=0x00000000 and in=0x80000000 -> 0x3FFFFFFF each. With INV_SQRT_STATS_EN, nonpos_cnt=2.
- Back-to-back stream of 8 inputs (the values above, tags 0..7), out_ready toggled 1,0,0,1 repeatedly -> results in order, none lost or duplicated, outputs stable while stalled.
- Reset asserted mid-stream with 3 entries in flight -> out_valid=0 and busy=0 immediately; no stale result appears after reset release.
- Random 10k positive inputs compared against the C reference Inv_sqrt -> bit-exact match for OUT_REG=0 and OUT_REG=1.
